// File: rtl/riscv_pkg.sv
// riscv_pkg: shared opcode/funct3 encodings, MEM-stage FSM state and alignment helper.
package riscv_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  typedef enum logic {IDLE, WAIT} mem_state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    return (size == 2'd1 && a[0]) || (size == 2'd2 && |a[1:0]) || (size == 2'd3 && |a);
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: shift the addressed lane of a 64-bit read word down and extend it by funct3.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_lane,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_result
);
  logic [XLEN-1:0] w_sh;
  assign w_sh = i_rdata >> {i_lane, 3'b000};
  always_comb
    o_result = i_funct3 == F3_B  ? {{(XLEN-8){w_sh[7]}}, w_sh[7:0]} :
               i_funct3 == F3_H  ? {{(XLEN-16){w_sh[15]}}, w_sh[15:0]} :
               i_funct3 == F3_W  ? {{(XLEN-32){w_sh[31]}}, w_sh[31:0]} :
               i_funct3 == F3_BU ? {{(XLEN-8){1'b0}}, w_sh[7:0]} :
               i_funct3 == F3_HU ? {{(XLEN-16){1'b0}}, w_sh[15:0]} :
               i_funct3 == F3_WU ? {{(XLEN-32){1'b0}}, w_sh[31:0]} :
               w_sh;
endmodule

// File: rtl/memory_stage.sv
// memory_stage: RV64 MEM stage issuing loads/stores over a req/ack port and
// registering the MEM/WB latch, stalling the pipe while an access is outstanding.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            MEM_V,
  input  logic [31:0]     MEM_IR,
  input  logic [XLEN-1:0] MEM_NPC,
  input  logic [XLEN-1:0] MEM_ALU_RESULT,
  input  logic [XLEN-1:0] MEM_SR2,
  input  logic [4:0]      MEM_DRID,
  input  logic [XLEN-1:0] MEM_CSRFD,
  input  logic [XLEN-1:0] MEM_RFD,
  input  logic            MEM_FLUSH,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [XLEN-1:0] DMEM_ADDR,
  output logic [XLEN-1:0] DMEM_WDATA,
  output logic [7:0]      DMEM_WSTRB,
  input  logic [XLEN-1:0] DMEM_RDATA,
  input  logic            DMEM_ACK,
  input  logic            DMEM_ERR,
  output logic            MEM_STALL,
  output logic            WB_V,
  output logic [31:0]     WB_IR,
  output logic [XLEN-1:0] WB_NPC,
  output logic [XLEN-1:0] WB_ALU_RESULT,
  output logic [XLEN-1:0] WB_MEM_RESULT,
  output logic [4:0]      WB_DRID,
  output logic [XLEN-1:0] WB_CSRFD,
  output logic [XLEN-1:0] WB_RFD,
  output logic            MEM_LAM,
  output logic            MEM_LAF,
  output logic            MEM_SAM,
  output logic            MEM_SAF
);
  mem_state_t      r_state;
  logic            r_kill;
  logic [2:0]      w_f3;
  logic [2:0]      w_lane;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_mis;
  logic            w_go;
  logic            w_v;
  logic            w_done;
  logic            w_err;
  logic [7:0]      w_mask;
  logic [7:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_ld;
  assign w_f3       = MEM_IR[14:12];
  assign w_lane     = MEM_ALU_RESULT[2:0];
  assign w_is_load  = MEM_V && MEM_IR[6:0] == OP_LOAD;
  // store funct3 above D is not a store; it flows through as a plain op
  assign w_is_store = MEM_V && MEM_IR[6:0] == OP_STORE && !w_f3[2];
  assign w_mis      = misaligned(w_f3[1:0], w_lane);
  assign w_go       = (w_is_load || w_is_store) && !w_mis && !MEM_FLUSH;
  assign MEM_STALL  = r_state == IDLE ? w_go : !DMEM_ACK;
  assign w_v        = MEM_V && !MEM_FLUSH && !r_kill;
  // latching while in WAIT only happens on the ack cycle
  assign w_done     = r_state == WAIT;
  assign w_err      = w_done && DMEM_ERR;
  always_comb begin
    w_mask  = w_f3[1:0] == 2'd0 ? 8'h01 : w_f3[1:0] == 2'd1 ? 8'h03 :
              w_f3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    w_wstrb = w_is_store ? w_mask << w_lane : 8'h00;
    w_wdata = w_f3[1:0] == 2'd0 ? {8{MEM_SR2[7:0]}} : w_f3[1:0] == 2'd1 ? {4{MEM_SR2[15:0]}} :
              w_f3[1:0] == 2'd2 ? {2{MEM_SR2[31:0]}} : MEM_SR2;
  end
  load_align #(.XLEN(XLEN)) u_align (
    .i_rdata (DMEM_RDATA),
    .i_lane  (w_lane),
    .i_funct3(w_f3),
    .o_result(w_ld)
  );
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state       <= IDLE;
      r_kill        <= 1'b0;
      DMEM_REQ      <= 1'b0;
      DMEM_WE       <= 1'b0;
      DMEM_ADDR     <= '0;
      DMEM_WDATA    <= '0;
      DMEM_WSTRB    <= '0;
      WB_V          <= 1'b0;
      WB_IR         <= '0;
      WB_NPC        <= '0;
      WB_ALU_RESULT <= '0;
      WB_MEM_RESULT <= '0;
      WB_DRID       <= '0;
      WB_CSRFD      <= '0;
      WB_RFD        <= '0;
      MEM_LAM       <= 1'b0;
      MEM_LAF       <= 1'b0;
      MEM_SAM       <= 1'b0;
      MEM_SAF       <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (w_go) begin
          r_state    <= WAIT;
          DMEM_REQ   <= 1'b1;
          DMEM_WE    <= w_is_store;
          DMEM_ADDR  <= {MEM_ALU_RESULT[XLEN-1:3], 3'b000};
          DMEM_WDATA <= w_wdata;
          DMEM_WSTRB <= w_wstrb;
        end
      end else if (DMEM_ACK) begin
        r_state  <= IDLE;
        DMEM_REQ <= 1'b0;
        r_kill   <= 1'b0;
      end else if (MEM_FLUSH) begin
        r_kill <= 1'b1;
      end
      if (!MEM_STALL) begin
        WB_V          <= w_v;
        WB_IR         <= MEM_IR;
        WB_NPC        <= MEM_NPC;
        WB_ALU_RESULT <= MEM_ALU_RESULT;
        WB_DRID       <= MEM_DRID;
        WB_CSRFD      <= MEM_CSRFD;
        WB_RFD        <= MEM_RFD;
        WB_MEM_RESULT <= (w_v && w_is_load && w_done && !DMEM_ERR) ? w_ld : '0;
        MEM_LAM       <= w_v && w_is_load && w_mis;
        MEM_SAM       <= w_v && w_is_store && w_mis;
        MEM_LAF       <= w_v && w_is_load && w_err;
        MEM_SAF       <= w_v && w_is_store && w_err;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed-vector bench for memory_stage with hand-computed expectations.
module tb_memory_stage;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MEM_V = 1'b0;
  logic [31:0] MEM_IR = '0;
  logic [63:0] MEM_NPC = '0, MEM_ALU_RESULT = '0, MEM_SR2 = '0;
  logic [4:0]  MEM_DRID = '0;
  logic [63:0] MEM_CSRFD = '0, MEM_RFD = '0;
  logic        MEM_FLUSH = 1'b0;
  logic        DMEM_REQ, DMEM_WE;
  logic [63:0] DMEM_ADDR, DMEM_WDATA;
  logic [7:0]  DMEM_WSTRB;
  logic [63:0] DMEM_RDATA = '0;
  logic        DMEM_ACK = 1'b0, DMEM_ERR = 1'b0;
  logic        MEM_STALL, WB_V;
  logic [31:0] WB_IR;
  logic [63:0] WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT;
  logic [4:0]  WB_DRID;
  logic [63:0] WB_CSRFD, WB_RFD;
  logic        MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF;
  int          n_chk = 0, n_fail = 0, n_stall;

  memory_stage dut (
    .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_NPC(MEM_NPC),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_SR2(MEM_SR2), .MEM_DRID(MEM_DRID),
    .MEM_CSRFD(MEM_CSRFD), .MEM_RFD(MEM_RFD), .MEM_FLUSH(MEM_FLUSH),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_WSTRB(DMEM_WSTRB), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK), .DMEM_ERR(DMEM_ERR),
    .MEM_STALL(MEM_STALL), .WB_V(WB_V), .WB_IR(WB_IR), .WB_NPC(WB_NPC),
    .WB_ALU_RESULT(WB_ALU_RESULT), .WB_MEM_RESULT(WB_MEM_RESULT), .WB_DRID(WB_DRID),
    .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD), .MEM_LAM(MEM_LAM), .MEM_LAF(MEM_LAF),
    .MEM_SAM(MEM_SAM), .MEM_SAF(MEM_SAF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [63:0] a, input logic [63:0] sr2);
    MEM_V = 1'b1;
    MEM_IR = ir;
    MEM_ALU_RESULT = a;
    MEM_SR2 = sr2;
    MEM_NPC = a + 64'h100;
    MEM_DRID = 5'd7;
  endtask

  task automatic flags(input string tag, input logic [3:0] exp);
    chk(tag, {60'd0, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF}, {60'd0, exp});
  endtask

  initial begin
    #1;
    chk("rst_req", DMEM_REQ, 0);
    chk("rst_wbv", WB_V, 0);
    chk("rst_stall", MEM_STALL, 0);
    tick;
    RESET = 1'b0;
    tick;

    // LW a=0x1004
    issue(32'h00002003, 64'h1004, 64'h0);
    MEM_CSRFD = 64'hC5C5;
    MEM_RFD = 64'h5A5A;
    #1;
    chk("lw_stall_idle", MEM_STALL, 1);
    tick;
    chk("lw_req", DMEM_REQ, 1);
    chk("lw_we", DMEM_WE, 0);
    chk("lw_addr", DMEM_ADDR, 64'h1000);
    chk("lw_wstrb", DMEM_WSTRB, 0);
    chk("lw_wbv_held", WB_V, 0);
    DMEM_ACK = 1'b1;
    DMEM_RDATA = 64'h80000000_12345678;
    #1;
    chk("lw_stall_ack", MEM_STALL, 0);
    tick;
    DMEM_ACK = 1'b0;
    MEM_V = 1'b0;
    chk("lw_wbv", WB_V, 1);
    chk("lw_result", WB_MEM_RESULT, 64'hFFFFFFFF_80000000);
    chk("lw_ir", WB_IR, 32'h00002003);
    chk("lw_npc", WB_NPC, 64'h1104);
    chk("lw_csrfd", WB_CSRFD, 64'hC5C5);
    chk("lw_rfd", WB_RFD, 64'h5A5A);
    chk("lw_drid", WB_DRID, 5'd7);
    chk("lw_req_drop", DMEM_REQ, 0);
    flags("lw_flags", 4'b0000);

    // SH a=0x2006
    issue(32'h00001023, 64'h2006, 64'h1111_ABCD);
    tick;
    chk("sh_req", DMEM_REQ, 1);
    chk("sh_we", DMEM_WE, 1);
    chk("sh_addr", DMEM_ADDR, 64'h2000);
    chk("sh_wstrb", DMEM_WSTRB, 8'hC0);
    chk("sh_wdata", DMEM_WDATA, 64'hABCDABCD_ABCDABCD);
    DMEM_ACK = 1'b1;
    DMEM_RDATA = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    DMEM_ACK = 1'b0;
    MEM_V = 1'b0;
    chk("sh_wbv", WB_V, 1);
    chk("sh_result", WB_MEM_RESULT, 0);
    flags("sh_flags", 4'b0000);

    // LD misaligned
    issue(32'h00003003, 64'h3004, 64'h0);
    #1;
    chk("ld_mis_stall", MEM_STALL, 0);
    tick;
    chk("ld_mis_req", DMEM_REQ, 0);
    chk("ld_mis_wbv", WB_V, 1);
    flags("ld_mis_flags", 4'b1000);
    issue(32'h00002023, 64'h3002, 64'h0);
    #1;
    chk("sw_mis_stall", MEM_STALL, 0);
    tick;
    chk("sw_mis_req", DMEM_REQ, 0);
    flags("sw_mis_flags", 4'b0010);

    // non-memory ops: ADD and store-opcode with funct3=100
    issue(32'h00000033, 64'h3001, 64'h0);
    #1;
    chk("add_stall", MEM_STALL, 0);
    tick;
    chk("add_wbv", WB_V, 1);
    chk("add_alu", WB_ALU_RESULT, 64'h3001);
    issue(32'h00004023, 64'h3003, 64'h0);
    #1;
    chk("st4_stall", MEM_STALL, 0);
    tick;
    chk("st4_req", DMEM_REQ, 0);
    chk("st4_wbv", WB_V, 1);
    flags("st4_flags", 4'b0000);

    // LBU with 3 wait cycles then ACK+ERR
    issue(32'h00004003, 64'h4003, 64'h0);
    n_stall = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (MEM_STALL) n_stall++;
      tick;
    end
    DMEM_ACK = 1'b1;
    DMEM_ERR = 1'b1;
    DMEM_RDATA = 64'h1234_5678_9ABC_DEF0;
    #1;
    chk("lbu_stall_cycles", n_stall, 4);
    chk("lbu_stall_ack", MEM_STALL, 0);
    tick;
    DMEM_ACK = 1'b0;
    DMEM_ERR = 1'b0;
    MEM_V = 1'b0;
    chk("lbu_wbv", WB_V, 1);
    chk("lbu_result", WB_MEM_RESULT, 0);
    flags("lbu_flags", 4'b0100);

    // SD with ERR
    issue(32'h00003023, 64'h4008, 64'h0123_4567_89AB_CDEF);
    tick;
    chk("sd_wstrb", DMEM_WSTRB, 8'hFF);
    chk("sd_wdata", DMEM_WDATA, 64'h0123_4567_89AB_CDEF);
    DMEM_ACK = 1'b1;
    DMEM_ERR = 1'b1;
    tick;
    DMEM_ACK = 1'b0;
    DMEM_ERR = 1'b0;
    MEM_V = 1'b0;
    flags("sd_flags", 4'b0001);

    // LD flushed while in WAIT
    issue(32'h00003003, 64'h5000, 64'h0);
    tick;
    MEM_FLUSH = 1'b1;
    tick;
    MEM_FLUSH = 1'b0;
    chk("kill_req1", DMEM_REQ, 1);
    chk("kill_stall", MEM_STALL, 1);
    tick;
    chk("kill_req2", DMEM_REQ, 1);
    DMEM_ACK = 1'b1;
    DMEM_RDATA = 64'h7777_7777_7777_7777;
    tick;
    DMEM_ACK = 1'b0;
    chk("kill_wbv", WB_V, 0);
    chk("kill_result", WB_MEM_RESULT, 0);
    chk("kill_req_drop", DMEM_REQ, 0);
    flags("kill_flags", 4'b0000);

    // next instruction LB a=0x6005 latches normally
    issue(32'h00000003, 64'h6005, 64'h0);
    tick;
    chk("lb_req", DMEM_REQ, 1);
    DMEM_ACK = 1'b1;
    DMEM_RDATA = 64'h0000_9A00_0000_0000;
    tick;
    DMEM_ACK = 1'b0;
    chk("lb_wbv", WB_V, 1);
    chk("lb_result", WB_MEM_RESULT, 64'hFFFF_FFFF_FFFF_FF9A);

    // flush in IDLE: no request, invalid latch
    issue(32'h00003003, 64'h7000, 64'h0);
    MEM_FLUSH = 1'b1;
    #1;
    chk("fi_stall", MEM_STALL, 0);
    tick;
    MEM_FLUSH = 1'b0;
    chk("fi_req", DMEM_REQ, 0);
    chk("fi_wbv", WB_V, 0);

    // LHU a=0x7002 to latch a valid entry before reset
    issue(32'h00005003, 64'h7002, 64'h0);
    tick;
    DMEM_ACK = 1'b1;
    DMEM_RDATA = 64'h0000_0000_8765_0000;
    tick;
    DMEM_ACK = 1'b0;
    chk("lhu_result", WB_MEM_RESULT, 64'h8765);
    chk("lhu_wbv", WB_V, 1);

    // reset mid-WAIT
    issue(32'h00002003, 64'h8000, 64'h0);
    tick;
    chk("pre_rst_req", DMEM_REQ, 1);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_req", DMEM_REQ, 0);
    chk("arst_wbv", WB_V, 0);
    chk("arst_ir", WB_IR, 0);
    chk("arst_alu", WB_ALU_RESULT, 0);
    chk("arst_result", WB_MEM_RESULT, 0);
    tick;
    RESET = 1'b0;
    DMEM_ACK = 1'b1;
    #1;
    chk("post_rst_idle", MEM_STALL, 1);
    DMEM_ACK = 1'b0;
    tick;
    chk("post_rst_req", DMEM_REQ, 1);
    DMEM_ACK = 1'b1;
    DMEM_RDATA = 64'h0000_0000_0000_0042;
    tick;
    DMEM_ACK = 1'b0;
    MEM_V = 1'b0;
    chk("post_rst_result", WB_MEM_RESULT, 64'h42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name:
memory_stage

Overview:
- RV64 pipeline MEM stage, directly upstream of writeback; registers the MEM/WB latch that writeback consumes.
- Performs loads and stores over a req/ack data-memory port: alignment check, byte-lane steering, sign/zero extension, fault reporting.
- Holds the pipeline via MEM_STALL while a memory access is outstanding.

Parameters:
XLEN, 64, datapath and address width; only 64 is supported.

Ports:
CLK  in  1  clock; all state on rising edge
RESET  in  1  asynchronous, active-high reset
MEM_V  in  1  instruction in MEM is valid
MEM_IR  in  32  instruction word; opcode [6:0], funct3 [14:12]
MEM_NPC  in  64  PC+4 of instruction
MEM_ALU_RESULT  in  64  effective address for ld/st, else ALU result
MEM_SR2  in  64  store data (rs2)
MEM_DRID  in  5  destination register id
MEM_CSRFD  in  64  CSR write data, passed through
MEM_RFD  in  64  CSR-read RF data, passed through
MEM_FLUSH  in  1  kill instruction in MEM (trap or redirect)
DMEM_REQ  out  1  request valid, held until DMEM_ACK
DMEM_WE  out  1  1 = store
DMEM_ADDR  out  64  8-byte-aligned address {addr[63:3],3'b0}
DMEM_WDATA  out  64  lane-replicated store data
DMEM_WSTRB  out  8  byte enables
DMEM_RDATA  in  64  read data; valid with DMEM_ACK
DMEM_ACK  in  1  access complete, one-cycle pulse
DMEM_ERR  in  1  access fault; sampled only with DMEM_ACK
MEM_STALL  out  1  freeze upstream stages and the MEM latch inputs
WB_V  out  1  WB latch valid
WB_IR  out  32  latched instruction
WB_NPC  out  64  latched NPC
WB_ALU_RESULT  out  64  latched ALU result / branch target
WB_MEM_RESULT  out  64  extended load data; 0 for non-loads and faults
WB_DRID  out  5  latched destination id
WB_CSRFD  out  64  latched CSR data
WB_RFD  out  64  latched RF data
MEM_LAM  out  1  load address misaligned, aligned with WB_V
MEM_LAF  out  1  load access fault
MEM_SAM  out  1  store address misaligned
MEM_SAF  out  1  store access fault

Behaviour:
- Reset, async: state IDLE, kill flag 0, every output 0 (DMEM_REQ drops immediately, even mid-access). Memory op = MEM_V and opcode 0000011 (load) or 0100011 (store). Store funct3 > 011 passes through as a non-memory op. Size from funct3[1:0]: B, H, W, D. Misaligned when H and a[0], W and a[1:0] != 0, or D and a[2:0] != 0.
- FSM IDLE -> WAIT when memory op is aligned and MEM_FLUSH=0. WAIT -> IDLE on DMEM_ACK. DMEM_REQ/WE/ADDR/WDATA/WSTRB are registered on the IDLE->WAIT edge and held stable through WAIT. Request to ack takes at least 1 cycle, so a load completes in 2 cycles at minimum.
- MEM_STALL (combinational) = aligned memory op with MEM_FLUSH=0 in IDLE, or WAIT and !DMEM_ACK. Misaligned ops and non-memory ops never stall or issue a request.
- WB latch loads on each cycle with MEM_STALL=0: WB_V <= MEM_V & !MEM_FLUSH & !kill. Other WB_* fields copy their MEM_* sources. Fault flags register together with WB_V and are 0 when WB_V is 0.
- Load extract: lane = addr[2:0]; shift RDATA right by 8*lane, then extend by funct3. LB/LH/LW/LD sign-extend; LBU/LHU/LWU zero-extend.
- Store: WSTRB = (B:0x01, H:0x03, W:0x0F, D:0xFF) << addr[2:0]. WDATA replicates the low B/H/W bytes across all lanes.
- DMEM_ERR with ACK: LAF or SAF set, WB_MEM_RESULT=0.
- MEM_FLUSH during WAIT: the bus cannot be aborted. Set kill; the access finishes, then latches with WB_V=0, no fault reported; kill clears on ACK.
- MEM_FLUSH in IDLE: no request is issued; the latched instruction is invalid.

Decomposition:
- Shared package riscv_pkg: OP_LOAD/OP_STORE opcodes, F3_B/H/W/D/BU/HU/WU encodings, mem_state_t {IDLE, WAIT}.
- One combinational sub-module, load_align (rdata, lane, funct3 -> extended result). Store lane steering stays inline.

Test Plan:
- LW a=0x1004, RDATA=0x80000000_12345678, ACK next cycle -> DMEM_ADDR=0x1000, WSTRB=0, WB_MEM_RESULT=0xFFFFFFFF_80000000, WB_V=1, MEM_STALL high 1 cycle.
- SH a=0x2006, SR2=0xABCD -> DMEM_WE=1, ADDR=0x2000, WSTRB=0xC0, WDATA=0xABCDABCD_ABCDABCD, no WB_MEM_RESULT (0).
- LD a=0x3004 -> MEM_LAM=1 with WB_V=1, DMEM_REQ never asserts, MEM_STALL=0. SW a=0x3002 -> MEM_SAM=1.
- LBU a=0x4003, ACK+ERR after 3 wait cycles -> MEM_STALL high 4 cycles, MEM_LAF=1, WB_MEM_RESULT=0. Same on SD -> MEM_SAF=1.
- LD, MEM_FLUSH pulsed in WAIT, ACK 2 cycles later -> REQ held until ACK, WB_V=0, no fault flags. Next instruction latches normally.
- RESET asserted mid-WAIT -> DMEM_REQ and all WB_* drop to 0 without a clock edge; FSM in IDLE after release.
